tw_rom_seq_ctrl: RTL and testbench

// - Sequencer and loader for the 1024-point twiddle ROM (TW_ROM5-class, 128b entries as hi/lo 64b halves).
// - Loads 4 fresh stage-0 twiddle entries from a 64b valid/ready stream.

---
 rtl/tw_rom_pkg.sv | 32 +++
 rtl/tw_load_buf.sv | 40 ++++
 rtl/tw_rom_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tw_rom_seq_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tw_rom_pkg.sv
// Shared types and constants for the twiddle ROM sequencer/loader.
// FSM encoding, rom_w codes, state-port codes and default timing.
package tw_rom_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL_HI,
        S_BURST_HI,
        S_SEP,
        S_FILL_LO,
        S_BURST_LO,
        S_RUN,
        S_GAP,
        S_FIN
    } fsm_t;

    localparam logic [1:0] ROM_W_IDLE = 2'd0;
    localparam logic [1:0] ROM_W_HI   = 2'd1;
    localparam logic [1:0] ROM_W_LO   = 2'd2;

    localparam logic [3:0] ST_ACTIVE  = 4'd4;
    localparam logic [3:0] ST_IDLE    = 4'd0;

    localparam int DEF_STAGE_LEN = 1024;
    localparam int DEF_GAP_LEN   = 2;

    // Counter width able to index n values; never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tw_load_buf.sv
// NUM_ENT x HDW staging buffer for one half of the stage-0 twiddle entries.
// Words land at wr_ptr; the burst side reads at rd_ptr; clr empties the count.
module tw_load_buf
    import tw_rom_pkg::*;
#(
    parameter int HDW     = 64,
    parameter int NUM_ENT = 4,
    parameter int PW      = cnt_width(NUM_ENT),
    parameter int CNTW    = cnt_width(NUM_ENT + 1)
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            wr_en,
    input  logic [PW-1:0]   wr_ptr,
    input  logic [HDW-1:0]  wr_data,
    input  logic [PW-1:0]   rd_ptr,
    output logic [HDW-1:0]  rd_data,
    output logic [CNTW-1:0] count
);

    logic [HDW-1:0] mem [NUM_ENT];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                mem[i] <= '0;
            end
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            count       <= count + CNTW'(1);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/tw_rom_seq_ctrl.sv
// Loader and stage sequencer for the 1024-point twiddle ROM: fills hi/lo halves
// from a valid/ready stream as gap-free bursts, then walks CEN through one NTT pass.
module tw_rom_seq_ctrl
    import tw_rom_pkg::*;
#(
    parameter int SC_WIDTH  = 3,
    parameter int S_WIDTH   = 4,
    parameter int HDW       = 64,
    parameter int NUM_ENT   = 4,
    parameter int STAGE_NUM = 3,
    parameter int STAGE_LEN = DEF_STAGE_LEN,
    parameter int GAP_LEN   = DEF_GAP_LEN
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                start,
    input  logic                load_req,
    input  logic                abort,
    input  logic                tf_valid,
    input  logic [HDW-1:0]      tf_data,
    output logic                tf_ready,
    output logic [1:0]          rom_w,
    output logic [HDW-1:0]      horizontal_tf_out,
    output logic                CEN,
    output logic [SC_WIDTH-1:0] stage_counter,
    output logic [S_WIDTH-1:0]  state,
    output logic                q_valid,
    output logic                busy,
    output logic                done
);

    localparam int RCW  = cnt_width(STAGE_LEN);
    localparam int GCW  = cnt_width(GAP_LEN);
    localparam int PW   = cnt_width(NUM_ENT);
    localparam int CNTW = cnt_width(NUM_ENT + 1);

    fsm_t                fsm_q, fsm_d;
    logic [RCW-1:0]      run_cnt_q, run_cnt_d;
    logic [GCW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [PW-1:0]       beat_q, beat_d;
    logic [SC_WIDTH-1:0] stage_q, stage_d;
    logic                pend_start_q, pend_start_d;
    logic                pend_load_q, pend_load_d;
    logic                buf_clr, buf_wr;
    logic [CNTW-1:0]     buf_cnt;
    logic [HDW-1:0]      buf_rd;

    tw_load_buf #(
        .HDW     (HDW),
        .NUM_ENT (NUM_ENT),
        .PW      (PW),
        .CNTW    (CNTW)
    ) u_buf (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_ptr  (buf_cnt[PW-1:0]),
        .wr_data (tf_data),
        .rd_ptr  (beat_q),
        .rd_data (buf_rd),
        .count   (buf_cnt)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= S_IDLE;
            run_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            beat_q       <= '0;
            stage_q      <= '0;
            pend_start_q <= 1'b0;
            pend_load_q  <= 1'b0;
            q_valid      <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            run_cnt_q    <= run_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            beat_q       <= beat_d;
            stage_q      <= stage_d;
            pend_start_q <= pend_start_d;
            pend_load_q  <= pend_load_d;
            q_valid      <= ~CEN;
        end
    end

    // Stream handshake: a word moves when tf_valid & tf_ready, only in FILL_x.
    always_comb begin
        fsm_d             = fsm_q;
        run_cnt_d         = run_cnt_q;
        gap_cnt_d         = gap_cnt_q;
        beat_d            = beat_q;
        stage_d           = stage_q;
        pend_start_d      = pend_start_q;
        pend_load_d       = pend_load_q;
        buf_clr           = 1'b0;
        buf_wr            = 1'b0;
        tf_ready          = 1'b0;
        rom_w             = ROM_W_IDLE;
        horizontal_tf_out = '0;
        CEN               = 1'b1;
        state             = S_WIDTH'(ST_IDLE);
        stage_counter     = SC_WIDTH'(STAGE_NUM);
        busy              = (fsm_q != S_IDLE);
        done              = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (load_req) begin
                    fsm_d        = S_FILL_HI;
                    pend_start_d = start;
                end else if (start) begin
                    fsm_d     = S_RUN;
                    stage_d   = '0;
                    run_cnt_d = '0;
                end
            end
            S_FILL_HI, S_FILL_LO: begin
                tf_ready = (buf_cnt < CNTW'(NUM_ENT)) && !abort;
                buf_wr   = tf_valid && tf_ready;
                if (buf_wr && (buf_cnt == CNTW'(NUM_ENT - 1))) begin
                    fsm_d  = (fsm_q == S_FILL_HI) ? S_BURST_HI : S_BURST_LO;
                    beat_d = '0;
                end
            end
            S_BURST_HI, S_BURST_LO: begin
                rom_w             = (fsm_q == S_BURST_HI) ? ROM_W_HI : ROM_W_LO;
                horizontal_tf_out = buf_rd;
                beat_d            = beat_q + PW'(1);
                if (beat_q == PW'(NUM_ENT - 1)) begin
                    beat_d  = '0;
                    buf_clr = 1'b1;
                    if (fsm_q == S_BURST_HI) begin
                        fsm_d = S_SEP;
                    end else if (pend_start_q) begin
                        fsm_d        = S_RUN;
                        stage_d      = '0;
                        run_cnt_d    = '0;
                        pend_start_d = 1'b0;
                    end else begin
                        fsm_d = S_IDLE;
                    end
                end
            end
            S_SEP: begin
                fsm_d = S_FILL_LO;
            end
            S_RUN: begin
                CEN           = 1'b0;
                state         = S_WIDTH'(ST_ACTIVE);
                stage_counter = stage_q;
                if (load_req) pend_load_d = 1'b1;
                run_cnt_d = run_cnt_q + RCW'(1);
                if (run_cnt_q == RCW'(STAGE_LEN - 1)) begin
                    run_cnt_d = '0;
                    gap_cnt_d = '0;
                    fsm_d     = (stage_q == SC_WIDTH'(STAGE_NUM - 1)) ? S_FIN : S_GAP;
                end
            end
            S_GAP: begin
                stage_counter = stage_q;
                if (load_req) pend_load_d = 1'b1;
                gap_cnt_d = gap_cnt_q + GCW'(1);
                if (gap_cnt_q == GCW'(GAP_LEN - 1)) begin
                    gap_cnt_d = '0;
                    run_cnt_d = '0;
                    stage_d   = stage_q + SC_WIDTH'(1);
                    fsm_d     = S_RUN;
                end
            end
            S_FIN: begin
                done        = !abort;
                stage_d     = '0;
                pend_load_d = 1'b0;
                fsm_d       = pend_load_q ? S_FILL_HI : S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase

        // Abort discards everything in flight; a half-written ROM must be reloaded.
        if (abort) begin
            fsm_d        = S_IDLE;
            run_cnt_d    = '0;
            gap_cnt_d    = '0;
            beat_d       = '0;
            stage_d      = '0;
            pend_start_d = 1'b0;
            pend_load_d  = 1'b0;
            buf_clr      = 1'b1;
        end
    end

endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// Directed bench for tw_rom_seq_ctrl: drivers push expected ROM writes, stage
// segments and done offsets into queues; a negedge monitor pops and compares.
module tb_tw_rom_seq_ctrl;

    localparam int HDW = 64;

    logic           CLK;
    logic           rst_n;
    logic           start;
    logic           load_req;
    logic           abort;
    logic           tf_valid;
    logic [HDW-1:0] tf_data;
    logic           tf_ready;
    logic [1:0]     rom_w;
    logic [HDW-1:0] horizontal_tf_out;
    logic           CEN;
    logic [2:0]     stage_counter;
    logic [3:0]     state;
    logic           q_valid;
    logic           busy;
    logic           done;

    tw_rom_seq_ctrl dut (
        .CLK               (CLK),
        .rst_n             (rst_n),
        .start             (start),
        .load_req          (load_req),
        .abort             (abort),
        .tf_valid          (tf_valid),
        .tf_data           (tf_data),
        .tf_ready          (tf_ready),
        .rom_w             (rom_w),
        .horizontal_tf_out (horizontal_tf_out),
        .CEN               (CEN),
        .stage_counter     (stage_counter),
        .state             (state),
        .q_valid           (q_valid),
        .busy              (busy),
        .done              (done)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    // wr entry: [67:66] required previous-cycle rom_w (3 = any), [65:64] rom_w, [63:0] data
    logic [67:0] wr_q[$];
    // run entry: [32] bad flag, [31:24] stage, [23:8] length, [7:0] gap before (0 = any)
    logic [32:0] run_q[$];
    logic [15:0] done_q[$];

    task automatic chk(input string nm, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    function automatic logic [32:0] run_ent(input int stg, input int len, input int gap);
        return {1'b0, 8'(stg), 16'(len), 8'(gap)};
    endfunction

    // ---------------- monitor ----------------
    bit         in_run = 1'b0;
    bit         seg_bad;
    int         seg_len, seg_stage, seg_gap;
    int         seg_end_cyc = 0;
    int         run0_cyc = 0;
    logic [1:0] prev_rw = 2'd0;
    bit         prev_nc = 1'b0;
    int         qv_err = 0;

    always @(negedge CLK) begin
        if (rst_n) begin
            if (rom_w != 2'd0) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 68'(rom_w), 68'd0);
                end else begin
                    logic [67:0] e;
                    logic [1:0]  gp;
                    e  = wr_q.pop_front();
                    gp = (e[67:66] == 2'd3) ? 2'd3 : prev_rw;
                    chk("wr_beat", {gp, rom_w, horizontal_tf_out}, e);
                end
            end
            if (q_valid !== prev_nc) qv_err++;
            if (!CEN) begin
                if (!in_run) begin
                    in_run    = 1'b1;
                    seg_len   = 0;
                    seg_bad   = 1'b0;
                    seg_stage = int'(stage_counter);
                    seg_gap   = cyc - seg_end_cyc;
                    if (stage_counter == 3'd0) run0_cyc = cyc;
                end
                seg_len++;
                if (state != 4'd4 || int'(stage_counter) != seg_stage) seg_bad = 1'b1;
            end else if (in_run) begin
                in_run      = 1'b0;
                seg_end_cyc = cyc;
                if (run_q.size() == 0) begin
                    chk("run_unexpected", 68'(seg_len), 68'd0);
                end else begin
                    logic [32:0] e;
                    e = run_q.pop_front();
                    chk("run_segment",
                        68'({seg_bad, 8'(seg_stage), 16'(seg_len), (e[7:0] == 8'd0) ? 8'd0 : 8'(seg_gap)}),
                        68'(e));
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 68'(done), 68'd0);
                else chk("done_offset", 68'(cyc - run0_cyc), 68'(done_q.pop_front()));
            end
        end
        prev_rw = rom_w;
        prev_nc = ~CEN;
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_load(input logic [7:0] base);
        for (int i = 0; i < 4; i++)
            wr_q.push_back({(i == 0) ? 2'd3 : 2'd1, 2'd1, 64'(base) + 64'(i)});
        for (int i = 0; i < 4; i++)
            wr_q.push_back({(i == 0) ? 2'd0 : 2'd2, 2'd2, 64'(base) + 64'(4 + i)});
    endtask

    task automatic push_pass();
        run_q.push_back(run_ent(0, 1024, 0));
        run_q.push_back(run_ent(1, 1024, 2));
        run_q.push_back(run_ent(2, 1024, 2));
        done_q.push_back(16'd3076);
    endtask

    task automatic stream(input logic [7:0] base, input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            int k;
            if (toggle) begin
                tf_valid = 1'b0;
                tick();
            end
            tf_valid = 1'b1;
            tf_data  = 64'(base) + 64'(i);
            k = 0;
            while (!tf_ready && k < 64) begin
                tick();
                k++;
            end
            chk("stream_ready", 68'(tf_ready), 68'd1);
            if (!tf_ready) begin
                tf_valid = 1'b0;
                return;
            end
            tick();
        end
        tf_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound && busy; k++) tick();
        chk("busy_drop", 68'(busy), 68'd0);
    endtask

    // Waits for done; optionally pulses start at iteration pulse_at while busy.
    task automatic wait_done(input int bound, input int pulse_at, output int at);
        at = -1;
        for (int k = 0; k < bound; k++) begin
            if (done) begin
                at = cyc;
                break;
            end
            start = (k == pulse_at);
            tick();
        end
        start = 1'b0;
        chk("done_seen", 68'(at >= 0), 68'd1);
    endtask

    task automatic wait_stage1();
        for (int k = 0; k < 3000; k++) begin
            if (!CEN && stage_counter == 3'd1) break;
            tick();
        end
        chk("stage1_reached", 68'({CEN, stage_counter}), 68'({1'b0, 3'd1}));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cs, at;
        rst_n    = 1'b0;
        start    = 1'b0;
        load_req = 1'b0;
        abort    = 1'b0;
        tf_valid = 1'b0;
        tf_data  = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();

        // Reset / idle state; a stream word in IDLE is refused.
        tf_valid = 1'b1;
        tf_data  = 64'hFF;
        #1;
        chk("idle_cen", 68'(CEN), 68'd1);
        chk("idle_rom_w", 68'(rom_w), 68'd0);
        chk("idle_stage", 68'(stage_counter), 68'd3);
        chk("idle_busy", 68'(busy), 68'd0);
        chk("idle_tf_ready", 68'(tf_ready), 68'd0);
        chk("idle_misc", 68'({done, q_valid, state}), 68'd0);
        tf_valid = 1'b0;
        tick();

        // Back-to-back load.
        push_load(8'hA0);
        pulse_load();
        stream(8'hA0, 8, 1'b0);
        wait_idle(50);

        // Same load with a throttled stream.
        push_load(8'hA0);
        pulse_load();
        stream(8'hA0, 8, 1'b1);
        wait_idle(50);

        // Plain pass, with a start while busy that must be ignored.
        push_pass();
        start = 1'b1;
        cs    = cyc;
        tick();
        start = 1'b0;
        wait_done(4000, 500, at);
        chk("pass_latency", 68'(at - cs), 68'd3077);
        tick();
        chk("after_pass_busy", 68'({busy, stage_counter, CEN}), 68'({1'b0, 3'd3, 1'b1}));

        // start and load_req together: load first, then pass.
        push_load(8'hC0);
        push_pass();
        start    = 1'b1;
        load_req = 1'b1;
        tick();
        start    = 1'b0;
        load_req = 1'b0;
        stream(8'hC0, 8, 1'b0);
        wait_done(4000, -1, at);
        tick();
        chk("after_sl_busy", 68'(busy), 68'd0);

        // load_req during stage 1 is deferred until after done.
        push_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_stage1();
        repeat (100) tick();
        pulse_load();
        chk("deferred_no_fill", 68'(tf_ready), 68'd0);
        wait_done(4000, -1, at);
        tick();
        chk("deferred_fill", 68'({busy, tf_ready}), 68'({1'b1, 1'b1}));
        push_load(8'hD0);
        stream(8'hD0, 8, 1'b0);
        wait_idle(50);

        // Abort on hi burst beat 2.
        for (int i = 0; i < 3; i++)
            wr_q.push_back({(i == 0) ? 2'd3 : 2'd1, 2'd1, 64'hE0 + 64'(i)});
        pulse_load();
        stream(8'hE0, 4, 1'b0);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_burst_rom_w", 68'(rom_w), 68'd0);
        chk("abort_burst_busy", 68'(busy), 68'd0);
        repeat (20) tick();

        // Abort at stage-1 cycle 50: segment is 51 cycles long, no done.
        run_q.push_back(run_ent(0, 1024, 0));
        run_q.push_back(run_ent(1, 51, 2));
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_stage1();
        repeat (50) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_run_cen", 68'(CEN), 68'd1);
        chk("abort_run_idle", 68'({busy, stage_counter, done}), 68'({1'b0, 3'd3, 1'b0}));
        repeat (3200) tick();

        // Fresh pass after abort restarts at stage 0.
        push_pass();
        start = 1'b1;
        cs    = cyc;
        tick();
        start = 1'b0;
        chk("restart_stage0", 68'({CEN, stage_counter, state}), 68'({1'b0, 3'd0, 4'd4}));
        wait_done(4000, -1, at);
        chk("restart_latency", 68'(at - cs), 68'd3077);
        repeat (5) tick();

        chk("wr_q_left", 68'(wr_q.size()), 68'd0);
        chk("run_q_left", 68'(run_q.size()), 68'd0);
        chk("done_q_left", 68'(done_q.size()), 68'd0);
        chk("q_valid_lag_errs", 68'(qv_err), 68'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
